// File: rtl/interrupt_arbiter.sv
// -----------------------------------------------------------------------------
// interrupt_arbiter
//
// Level-sensitive interrupt controller with per-source enable and priority,
// a global priority threshold, and a claim/complete handshake on a small
// register bus. Drives a single external_interrupt line towards the CSR
// controller.
//
// Ports
//   clock               sole clock, rising edge
//   reset               asynchronous active-low reset
//   irq_sources         level requests, asynchronous to clock; bit i is ID i+1
//   bus_select          one-cycle bus access request
//   bus_write           1 = write, 0 = read (qualified by bus_select)
//   bus_address         byte offset, word aligned (bits [1:0] ignored)
//   bus_write_data      write data
//   bus_read_data       registered read data, held between reads
//   bus_ready           one-cycle completion pulse, one cycle after bus_select
//   external_interrupt  OR of all eligible sources
//
// Register map (word offset)
//   0x00 PENDING    RO  bits [SOURCES-1:0]
//   0x04 ENABLE     RW  bits [SOURCES-1:0]
//   0x08 THRESHOLD  RW  bits [2:0]
//   0x0C CLAIM      read returns winner ID and claims it; write ID completes it
//   0x10 PRIORITY   RW  source i in bits [4i+2:4i] (SOURCES <= 8)
// -----------------------------------------------------------------------------
module interrupt_arbiter #(
    parameter int SOURCES = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [SOURCES-1:0] irq_sources,
    input  logic               bus_select,
    input  logic               bus_write,
    input  logic [4:0]         bus_address,
    input  logic [31:0]        bus_write_data,
    output logic [31:0]        bus_read_data,
    output logic               bus_ready,
    output logic               external_interrupt
);

    localparam int ID_W = $clog2(SOURCES + 1);

    localparam logic [2:0] WORD_PENDING   = 3'd0;
    localparam logic [2:0] WORD_ENABLE    = 3'd1;
    localparam logic [2:0] WORD_THRESHOLD = 3'd2;
    localparam logic [2:0] WORD_CLAIM     = 3'd3;
    localparam logic [2:0] WORD_PRIORITY  = 3'd4;

    // State
    logic [SOURCES-1:0] sync1_r;
    logic [SOURCES-1:0] sync2_r;
    logic [SOURCES-1:0] pending_r;
    logic [SOURCES-1:0] in_service_r;
    logic [SOURCES-1:0] enable_r;
    logic [2:0]         threshold_r;
    logic [2:0]         priority_r [SOURCES];
    logic [31:0]        read_data_r;
    logic               ready_r;

    // Decode and arbitration
    logic [2:0]         word_s;
    logic               rd_s;
    logic               wr_s;
    logic               claim_s;
    logic               complete_s;
    logic [SOURCES-1:0] eligible_s;
    logic [ID_W-1:0]    winner_id_s;
    logic [SOURCES-1:0] winner_oh_s;
    logic [2:0]         best_prio_s;
    logic [SOURCES-1:0] claim_oh_s;
    logic [SOURCES-1:0] complete_oh_s;
    logic [31:0]        priority_packed_s;
    logic [31:0]        rd_data_s;
    logic               unused_s;

    assign word_s     = bus_address[4:2];
    assign unused_s   = ^bus_address[1:0];
    assign rd_s       = bus_select & ~bus_write;
    assign wr_s       = bus_select & bus_write;
    assign claim_s    = rd_s & (word_s == WORD_CLAIM);
    assign complete_s = wr_s & (word_s == WORD_CLAIM);

    // Eligibility and winner selection; strict '>' keeps the lowest ID on ties
    always_comb begin
        best_prio_s = 3'd0;
        winner_id_s = '0;
        winner_oh_s = '0;
        eligible_s  = '0;
        for (int i = 0; i < SOURCES; i++) begin
            eligible_s[i] = pending_r[i] & enable_r[i] & (priority_r[i] > threshold_r);
            if (eligible_s[i] && (priority_r[i] > best_prio_s)) begin
                best_prio_s = priority_r[i];
                winner_id_s = ID_W'(i + 1);
                winner_oh_s = SOURCES'(1'b1) << i;
            end else begin
                best_prio_s = best_prio_s;
            end
        end
    end

    assign claim_oh_s         = claim_s ? winner_oh_s : '0;
    assign external_interrupt = |eligible_s;

    // Complete decode: only IDs 1..SOURCES match a bit, so 0 and out-of-range IDs fall away
    always_comb begin
        complete_oh_s = '0;
        for (int i = 0; i < SOURCES; i++) begin
            complete_oh_s[i] = complete_s & (bus_write_data == 32'(i + 1));
        end
    end

    // Pack per-source priorities into the PRIORITY register image
    always_comb begin
        priority_packed_s = 32'd0;
        for (int i = 0; i < SOURCES; i++) begin
            priority_packed_s[4*i +: 3] = priority_r[i];
        end
    end

    // Read data multiplexer
    always_comb begin
        rd_data_s = 32'd0;
        case (word_s)
            WORD_PENDING:   rd_data_s = 32'(pending_r);
            WORD_ENABLE:    rd_data_s = 32'(enable_r);
            WORD_THRESHOLD: rd_data_s = 32'(threshold_r);
            WORD_CLAIM:     rd_data_s = 32'(winner_id_s);
            WORD_PRIORITY:  rd_data_s = priority_packed_s;
            default:        rd_data_s = 32'd0;
        endcase
    end

    // Two-flop synchronizer per source
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= irq_sources;
            sync2_r <= sync1_r;
        end
    end

    // Pending / in-service tracking; a claimed source cannot re-pend until completed
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_r    <= '0;
            in_service_r <= '0;
        end else begin
            pending_r    <= (pending_r | (sync2_r & ~in_service_r)) & ~claim_oh_s;
            in_service_r <= (in_service_r | claim_oh_s) & ~complete_oh_s;
        end
    end

    // Configuration registers written over the bus
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enable_r    <= '0;
            threshold_r <= 3'd0;
            for (int i = 0; i < SOURCES; i++) begin
                priority_r[i] <= 3'd0;
            end
        end else if (wr_s) begin
            case (word_s)
                WORD_ENABLE:    enable_r    <= bus_write_data[SOURCES-1:0];
                WORD_THRESHOLD: threshold_r <= bus_write_data[2:0];
                WORD_PRIORITY: begin
                    for (int i = 0; i < SOURCES; i++) begin
                        priority_r[i] <= bus_write_data[4*i +: 3];
                    end
                end
                default: enable_r <= enable_r;
            endcase
        end else begin
            enable_r <= enable_r;
        end
    end

    // Registered bus response: read data captured on reads, ready for every access
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            read_data_r <= 32'd0;
            ready_r     <= 1'b0;
        end else begin
            read_data_r <= rd_s ? rd_data_s : read_data_r;
            ready_r     <= bus_select;
        end
    end

    assign bus_read_data = read_data_r;
    assign bus_ready     = ready_r;

endmodule
